mode_sequencer: RTL
===================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 2: number of selectable modes, legal range 2..16.
REQ-002 Parameter RESET_MODE, default 0: mode index loaded on reset, legal range 0..NUM_MODES-1.
REQ-003 Parameter AUTO_PERIOD, default 100000000: auto-advance interval in clk cycles, minimum 2.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 next_in  input  1  level request to advance one mode; only its rising edge acts.
REQ-007 prev_in  input  1  level request to step back one mode; only its rising edge acts.
REQ-008 set_en  input  1  single-cycle direct-load strobe.
REQ-009 set_mode  input  MW  target index for set_en, where MW = max(1, clog2(NUM_MODES)).
REQ-010 lock  input  1  when high, freezes mode against all requests except reset.
REQ-011 auto_en  input  1  when high, enables timed auto-advance.
REQ-012 mode  output  MW  registered current mode index.
REQ-013 mode_onehot  output  NUM_MODES  registered one-hot copy of mode.
REQ-014 mode_changed  output  1  registered one-cycle pulse, high in the first cycle a new mode value is visible.

Function
REQ-015 A rising edge is detected when the input is high in the current cycle and was low in the previous cycle; a held level acts exactly once.
REQ-016 Request latency: an event sampled at edge k updates mode at edge k; mode_changed is high for one cycle in the same cycle as the update.
REQ-017 Priority per cycle: lock, then set_en, then manual edge, then auto tick.
REQ-018 lock=1 blocks every update, discards any edge detected that cycle, and holds the auto counter at 0.
REQ-019 set_en with set_mode < NUM_MODES loads set_mode; set_mode >= NUM_MODES is ignored, and no manual or auto update is applied that cycle.
REQ-020 A next edge alone gives mode = (mode+1) mod NUM_MODES: NUM_MODES-1 wraps to 0.
REQ-021 A prev edge alone gives mode = (mode-1) mod NUM_MODES: 0 wraps to NUM_MODES-1.
REQ-022 Simultaneous next and prev edges cancel: mode is unchanged, and the auto counter is still cleared.
REQ-023 Auto counter: when auto_en=1, it counts 0..AUTO_PERIOD-1; at terminal count it produces a tick that advances the mode like a next edge, then returns to 0.
REQ-024 The auto counter clears to 0 when auto_en=0, on any accepted set or manual request, and on a lock.
REQ-025 mode_changed stays low when the new value equals the old one, including set_mode equal to the current mode.
REQ-026 mode_onehot always has exactly bit[mode] set.

Reset
REQ-027 On rst_n=0, asynchronously: mode=RESET_MODE, mode_onehot has bit RESET_MODE set, mode_changed=0, auto counter=0, and edge-detect history registers=1.
REQ-028 Edge history held at 1 on reset means an input already high at reset release does not generate an edge.
REQ-029 Reset asserted mid-operation aborts any pending count or request; no partial update survives.

Structure
REQ-030 A shared package holds the MW width function (clog2 helper) and the counter width derived from AUTO_PERIOD.
REQ-031 A sub-module rise_detect (clk, rst_n, in, rise) is instantiated twice, once for next_in and once for prev_in.
REQ-032 The mode register, auto counter and output registers reside in mode_sequencer.
REQ-033 Parameters out of their legal range are flagged by an elaboration-time check.

Verification
REQ-034 NUM_MODES=2, three next pulses from mode 0 -> mode 1,0,1 with mode_changed high for one cycle each, which is equivalent to a 12/24 toggle.
REQ-035 NUM_MODES=5, prev edge at mode 0 -> mode 4; then next held high 10 cycles -> mode 0 with exactly one mode_changed pulse.
REQ-036 NUM_MODES=5, set_en with set_mode=7 -> no change; set_en with set_mode=3 plus a simultaneous next edge -> mode 3.
REQ-037 AUTO_PERIOD=4, auto_en=1 -> advances every 4 cycles; a next edge at count 2 clears the counter, and the next auto step comes 4 cycles later.
REQ-038 lock=1 with next, prev, set_en and auto all active for 20 cycles -> mode constant and mode_changed=0.
REQ-039 next_in held high across reset release at RESET_MODE=2 -> mode stays 2; the first real edge gives 3; rst_n pulsed mid-count -> mode 2 and counter 0.

Source files
------------

// File: rtl/mode_sequencer_pkg.sv
// Shared width helpers and legal parameter limits for mode_sequencer.
package mode_sequencer_pkg;

   localparam int MIN_MODES       = 2;
   localparam int MAX_MODES       = 16;
   localparam int MIN_AUTO_PERIOD = 2;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // Width of a mode index; never narrower than one bit.
   function automatic int mode_width(input int num_modes);
      return (clog2(num_modes) < 1) ? 1 : clog2(num_modes);
   endfunction

   // Counter must hold 0..period-1.
   function automatic int cnt_width(input int period);
      return (clog2(period) < 1) ? 1 : clog2(period);
   endfunction

endpackage

// File: rtl/mode_sequencer_rise_detect.sv
// Rising-edge detector; history resets high so a level already present at reset release is ignored.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);

   logic hist_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist_reg <= 1'b1;
      else        hist_reg <= in;
   end

   assign rise = in & ~hist_reg;

endmodule

// File: rtl/mode_sequencer.sv
// Mode selector: manual next/prev edges, direct load, lock and timed auto-advance over NUM_MODES modes.
module mode_sequencer
   import mode_sequencer_pkg::*;
#(
   parameter  int NUM_MODES   = 2,
   parameter  int RESET_MODE  = 0,
   parameter  int AUTO_PERIOD = 100000000,
   localparam int MW          = mode_width(NUM_MODES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 next_in,
   input  logic                 prev_in,
   input  logic                 set_en,
   input  logic [MW-1:0]        set_mode,
   input  logic                 lock,
   input  logic                 auto_en,
   output logic [MW-1:0]        mode,
   output logic [NUM_MODES-1:0] mode_onehot,
   output logic                 mode_changed
);

   localparam int                   CW           = cnt_width(AUTO_PERIOD);
   localparam logic [MW-1:0]        LAST_MODE    = MW'(NUM_MODES - 1);
   localparam logic [MW-1:0]        RST_MODE     = MW'(RESET_MODE);
   localparam logic [CW-1:0]        CNT_LAST     = CW'(AUTO_PERIOD - 1);
   localparam logic [NUM_MODES-1:0] RESET_ONEHOT = {{(NUM_MODES-1){1'b0}}, 1'b1} << RESET_MODE;

   generate
      if (NUM_MODES < MIN_MODES || NUM_MODES > MAX_MODES) begin : g_bad_num_modes
         $error("mode_sequencer: NUM_MODES=%0d outside 2..16", NUM_MODES);
      end
      if (RESET_MODE < 0 || RESET_MODE >= NUM_MODES) begin : g_bad_reset_mode
         $error("mode_sequencer: RESET_MODE=%0d outside 0..NUM_MODES-1", RESET_MODE);
      end
      if (AUTO_PERIOD < MIN_AUTO_PERIOD) begin : g_bad_auto_period
         $error("mode_sequencer: AUTO_PERIOD=%0d below 2", AUTO_PERIOD);
      end
   endgenerate

   logic                 next_rise;
   logic                 prev_rise;
   logic [MW-1:0]        mode_reg;
   logic [MW-1:0]        mode_next;
   logic [MW-1:0]        mode_up;
   logic [MW-1:0]        mode_down;
   logic [CW-1:0]        cnt_reg;
   logic [CW-1:0]        cnt_next;
   logic [NUM_MODES-1:0] onehot_reg;
   logic [NUM_MODES-1:0] onehot_next;
   logic                 changed_reg;

   rise_detect u_next_rise (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (next_in),
      .rise (next_rise)
   );

   rise_detect u_prev_rise (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (prev_in),
      .rise (prev_rise)
   );

   assign mode_up   = (mode_reg == LAST_MODE) ? '0 : mode_reg + 1'b1;
   assign mode_down = (mode_reg == '0) ? LAST_MODE : mode_reg - 1'b1;

   // Counter defaults to clearing; only an idle auto-enabled cycle lets it advance.
   // A set_en strobe clears it even when its target is out of range.
   always_comb begin
      mode_next = mode_reg;
      cnt_next  = '0;
      if (lock) begin
         mode_next = mode_reg;
      end else if (set_en) begin
         if (int'(set_mode) < NUM_MODES) mode_next = set_mode;
      end else if (next_rise || prev_rise) begin
         if (next_rise && !prev_rise)      mode_next = mode_up;
         else if (prev_rise && !next_rise) mode_next = mode_down;
      end else if (auto_en) begin
         if (cnt_reg == CNT_LAST) mode_next = mode_up;
         else                     cnt_next  = cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_onehot
         assign onehot_next[gi] = (mode_next == MW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg    <= RST_MODE;
         onehot_reg  <= RESET_ONEHOT;
         changed_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         mode_reg    <= mode_next;
         onehot_reg  <= onehot_next;
         changed_reg <= (mode_next != mode_reg);
         cnt_reg     <= cnt_next;
      end
   end

   assign mode         = mode_reg;
   assign mode_onehot  = onehot_reg;
   assign mode_changed = changed_reg;

endmodule
